svm_dot_sched: RTL and testbench
================================

# svm_dot_sched

Sequencer for the shared pipelined sign-magnitude Q1.16 multiplier in the SVM kernel datapath. It accepts a dot-product command, reads operand pairs from the support-vector and test-vector RAMs, and streams them through the multiplier. It tags each operand pair with a valid bit that tracks the multiplier latency, and accumulates the 32-bit products into a saturating signed accumulator. The result is presented to the kernel/decision stage with a one-cycle valid pulse.

## Interface
- LEN_W, 8: width of command vector length.
- ADDR_W, 8: RAM address width.
- DATA_W, 17: operand width (sign + 16-bit magnitude, Q1.16).
- PROD_W, 32: multiplier result width (two's complement, Q.16).
- ACC_W, 40: accumulator width (signed).
- MUL_LAT, 10: cycles from operands on mul_a/mul_b (with mul_start high) to product on mul_data.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_len  in  LEN_W  number of element pairs N.
- cmd_base_a / cmd_base_b  in  ADDR_W  start addresses.
- ram_a_en / ram_b_en  out  1  read enables.
- ram_a_addr / ram_b_addr  out  ADDR_W  read addresses.
- ram_a_data / ram_b_data  in  DATA_W  read data; 1-cycle read latency.
- mul_a / mul_b  out  DATA_W  multiplier operands, driven directly from RAM data.
- mul_start  out  1  multiplier pipeline advance.
- mul_data  in  PROD_W  multiplier product.
- acc_out  out  ACC_W  dot-product result.
- acc_valid  out  1  one-cycle result strobe.
- acc_ovf  out  1  sticky saturation flag for the current command.
- busy  out  1  high whenever the state is not IDLE.

## Operation
States:
- IDLE: cmd_ready=1. On cmd_valid, latch len/bases, clear acc and acc_ovf, set i=0.
  - N≠0 → ISSUE.
  - N=0 → DONE.
- ISSUE: ram_*_en=1 and addr=base+i, wrapping mod 2^ADDR_W. i increments each cycle. After N cycles → DRAIN.
- DRAIN: wait until the valid-tag shift register (1+MUL_LAT stages) is empty → DONE.
- DONE: one cycle; acc_valid=1; → IDLE.

Datapath rules:
- mul_start is 1 from ISSUE entry through the final DRAIN cycle, and 0 in IDLE and DONE. It is held high continuously so the multiplier never stalls mid-job.
- The valid tag is injected per issued address. It is 1 cycle late for the RAM read, then shifted MUL_LAT cycles. Products without a tag are ignored; this covers multiplier warm-up garbage.
- Accumulate: acc += sign-extend(mul_data) to ACC_W+1 bits.
  - If the result is > 2^(ACC_W-1)-1 or < -2^(ACC_W-1), clamp to that limit and set acc_ovf.
  - Later products continue from the clamped value.
- acc_out and acc_ovf hold until the next command is accepted.

## Timing
- Command accepted at edge T0.
- ISSUE occupies cycles T0+1 … T0+N.
- Element k (k=0..N-1) is on mul_a/mul_b in cycle T0+k+2 and on mul_data in cycle T0+k+2+MUL_LAT.
- acc_valid occurs in cycle T0+N+MUL_LAT+2. Throughput is 1 pair/cycle.
- N=0: acc_valid occurs in cycle T0+1 with acc_out=0.
- cmd_valid outside IDLE is ignored (cmd_ready=0). The next accept is possible in the cycle after DONE.
- Reset values: cmd_ready=1, busy=0, ram_*_en=0, addresses=0, mul_a/mul_b=0, mul_start=0, acc_out=0, acc_valid=0, acc_ovf=0, state IDLE.
- Reset mid-operation clears the tag pipeline and aborts the job. No acc_valid follows.

## Structure
- Package svm_sched_pkg holds:
  - state enum {IDLE, ISSUE, DRAIN, DONE};
  - default widths;
  - MUL_LAT.
- Sub-module svm_sat_acc: clear, valid-gated signed add with clamp and sticky overflow.
- Controller FSM, address counters and tag shift register live in svm_dot_sched.

## Test plan
The bench uses a behavioural multiplier model with MUL_LAT latency.
- Positive sum: N=4, all a=0x0C000, all b=0x04000 → products 0x3000 each. acc_out=0xC000, acc_valid at T0+16, acc_ovf=0.
- Negative operand: N=2, a=0x18000, b=0x08000 → products 0xFFFFC000. acc_out=-0x8000 (sign-extended), acc_ovf=0.
- Zero length: cmd_len=0 → acc_valid in cycle T0+1, acc_out=0, mul_start never asserted.
- Address wrap: base_a=0xFE, N=4 → ram_a_addr sequence 0xFE, 0xFF, 0x00, 0x01. Back-to-back cmd_valid during busy is ignored.
- Saturation: ACC_W=34, model returns 0x7FFFFFFF, N=5 → acc_out=0x1FFFFFFFF, acc_ovf=1. The next command clears acc_ovf.
- Reset mid-op: assert rst_n=0 during DRAIN → all outputs return to reset values immediately, and no acc_valid follows.

Source files
------------

// File: rtl/svm_sched_pkg.sv
// Shared types and default widths for the SVM dot-product multiplier sequencer.
// The multiplier latency lives here so that datapath and controller agree on it.
package svm_sched_pkg;

  localparam int DEF_LEN_W   = 8;
  localparam int DEF_ADDR_W  = 8;
  localparam int DEF_DATA_W  = 17;
  localparam int DEF_PROD_W  = 32;
  localparam int DEF_ACC_W   = 40;
  localparam int DEF_MUL_LAT = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } sched_state_e;

endpackage

// File: rtl/svm_sat_acc.sv
// Saturating signed accumulator: synchronous clear, valid-gated add of a
// sign-extended product, clamp to the ACC_W range and sticky overflow flag.
module svm_sat_acc
  import svm_sched_pkg::*;
#(
  parameter int IN_W  = DEF_PROD_W,
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             vld,
  input  logic [IN_W-1:0]  din,
  output logic [ACC_W-1:0] acc,
  output logic             ovf
);

  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic [ACC_W:0]   sum_s;
  logic             hit_s;
  logic [ACC_W-1:0] nxt_s;

  // One guard bit catches overflow; the guard sign selects which limit to clamp to.
  always_comb begin
    sum_s = {acc[ACC_W-1], acc} + {{(ACC_W+1-IN_W){din[IN_W-1]}}, din};
    hit_s = sum_s[ACC_W] ^ sum_s[ACC_W-1];
    if (hit_s) begin
      nxt_s = sum_s[ACC_W] ? ACC_MIN : ACC_MAX;
    end else begin
      nxt_s = sum_s[ACC_W-1:0];
    end
  end

  // Accumulator and sticky flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (clr) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (vld) begin
      acc <= nxt_s;
      ovf <= ovf | hit_s;
    end
  end

endmodule

// File: rtl/svm_dot_sched.sv
// Dot-product sequencer: issues RAM reads, streams operand pairs through the
// shared pipelined multiplier and accumulates tagged products.
module svm_dot_sched
  import svm_sched_pkg::*;
#(
  parameter int LEN_W   = DEF_LEN_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int PROD_W  = DEF_PROD_W,
  parameter int ACC_W   = DEF_ACC_W,
  parameter int MUL_LAT = DEF_MUL_LAT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [ADDR_W-1:0] cmd_base_a,
  input  logic [ADDR_W-1:0] cmd_base_b,
  output logic              ram_a_en,
  output logic              ram_b_en,
  output logic [ADDR_W-1:0] ram_a_addr,
  output logic [ADDR_W-1:0] ram_b_addr,
  input  logic [DATA_W-1:0] ram_a_data,
  input  logic [DATA_W-1:0] ram_b_data,
  output logic [DATA_W-1:0] mul_a,
  output logic [DATA_W-1:0] mul_b,
  output logic              mul_start,
  input  logic [PROD_W-1:0] mul_data,
  output logic [ACC_W-1:0]  acc_out,
  output logic              acc_valid,
  output logic              acc_ovf,
  output logic              busy
);

  sched_state_e      state_r;
  sched_state_e      state_s;
  logic [LEN_W-1:0]  cnt_r;
  logic [ADDR_W-1:0] addr_a_r;
  logic [ADDR_W-1:0] addr_b_r;
  logic              ram_en_r;
  logic              mul_start_r;
  logic              acc_valid_r;
  logic              cmd_ready_r;
  logic              busy_r;
  // tag_r[0] marks an operand pair on mul_a/mul_b, tag_r[MUL_LAT] its product on mul_data.
  logic [MUL_LAT:0]  tag_r;
  logic              accept_s;

  assign accept_s = (state_r == IDLE) && cmd_valid;

  // Next-state logic of the job controller.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (cmd_valid) begin
          state_s = (cmd_len == '0) ? DONE : ISSUE;
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: begin
        if (cnt_r == LEN_W'(1)) begin
          state_s = DRAIN;
        end else begin
          state_s = ISSUE;
        end
      end
      DRAIN: begin
        // The last product is being accumulated once only the final stage holds a tag.
        if (tag_r[MUL_LAT-1:0] == '0) begin
          state_s = DONE;
        end else begin
          state_s = DRAIN;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register and outputs registered from the next state so they align with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      ram_en_r    <= 1'b0;
      mul_start_r <= 1'b0;
      acc_valid_r <= 1'b0;
      cmd_ready_r <= 1'b1;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      ram_en_r    <= (state_s == ISSUE);
      mul_start_r <= (state_s == ISSUE) || (state_s == DRAIN);
      acc_valid_r <= (state_s == DONE);
      cmd_ready_r <= (state_s == IDLE);
      busy_r      <= (state_s != IDLE);
    end
  end

  // Element counter and read addresses; addresses wrap naturally at 2^ADDR_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r    <= '0;
      addr_a_r <= '0;
      addr_b_r <= '0;
    end else if (accept_s) begin
      cnt_r    <= cmd_len;
      addr_a_r <= cmd_base_a;
      addr_b_r <= cmd_base_b;
    end else if ((state_r == ISSUE) && (state_s == ISSUE)) begin
      cnt_r    <= cnt_r - LEN_W'(1);
      addr_a_r <= addr_a_r + ADDR_W'(1);
      addr_b_r <= addr_b_r + ADDR_W'(1);
    end
  end

  // Valid-tag pipeline: one cycle for the RAM read, then MUL_LAT multiplier stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_r <= '0;
    end else begin
      tag_r <= {tag_r[MUL_LAT-1:0], ram_en_r};
    end
  end

  // Operands pass straight from RAM; forced to zero when no pair is in flight.
  always_comb begin
    if (tag_r[0]) begin
      mul_a = ram_a_data;
      mul_b = ram_b_data;
    end else begin
      mul_a = '0;
      mul_b = '0;
    end
  end

  svm_sat_acc #(
    .IN_W  (PROD_W),
    .ACC_W (ACC_W)
  ) u_acc (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (accept_s),
    .vld   (tag_r[MUL_LAT]),
    .din   (mul_data),
    .acc   (acc_out),
    .ovf   (acc_ovf)
  );

  assign cmd_ready  = cmd_ready_r;
  assign busy       = busy_r;
  assign ram_a_en   = ram_en_r;
  assign ram_b_en   = ram_en_r;
  assign ram_a_addr = addr_a_r;
  assign ram_b_addr = addr_b_r;
  assign mul_start  = mul_start_r;
  assign acc_valid  = acc_valid_r;

endmodule

// File: tb/tb_svm_dot_sched.sv
// Bench for svm_dot_sched: RAM and sign-magnitude multiplier models, a job-level
// reference model with per-cycle output checks, directed and random jobs.
module tb_svm_dot_sched;

  localparam int LEN_W  = 8;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 17;
  localparam int PROD_W = 32;
  localparam int ACC_W  = 34;
  localparam int LAT    = 10;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [LEN_W-1:0]  cmd_len = '0;
  logic [ADDR_W-1:0] cmd_base_a = '0;
  logic [ADDR_W-1:0] cmd_base_b = '0;
  logic              ram_a_en, ram_b_en;
  logic [ADDR_W-1:0] ram_a_addr, ram_b_addr;
  logic [DATA_W-1:0] ram_a_data = '0;
  logic [DATA_W-1:0] ram_b_data = '0;
  logic [DATA_W-1:0] mul_a, mul_b;
  logic              mul_start;
  logic [PROD_W-1:0] mul_data;
  logic [ACC_W-1:0]  acc_out;
  logic              acc_valid, acc_ovf, busy;

  always #5 clk = ~clk;

  svm_dot_sched #(
    .LEN_W(LEN_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .PROD_W(PROD_W), .ACC_W(ACC_W), .MUL_LAT(LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
    .cmd_base_a(cmd_base_a), .cmd_base_b(cmd_base_b),
    .ram_a_en(ram_a_en), .ram_b_en(ram_b_en),
    .ram_a_addr(ram_a_addr), .ram_b_addr(ram_b_addr),
    .ram_a_data(ram_a_data), .ram_b_data(ram_b_data),
    .mul_a(mul_a), .mul_b(mul_b), .mul_start(mul_start), .mul_data(mul_data),
    .acc_out(acc_out), .acc_valid(acc_valid), .acc_ovf(acc_ovf), .busy(busy)
  );

  int n_pass = 0;
  int n_tot  = 0;
  int cyc    = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h at cycle %0d", nm, act, exp, cyc);
  endtask

  // ---------------- RAM and multiplier models ----------------
  logic [DATA_W-1:0] mem_a [256];
  logic [DATA_W-1:0] mem_b [256];
  logic [PROD_W-1:0] pipe [LAT];
  bit                force_en = 1'b0;
  logic [31:0]       force_val = 32'h0;

  function automatic logic [31:0] mul_model(input logic [16:0] a, input logic [16:0] b);
    logic [31:0] m;
    m = (32'(a[15:0]) * 32'(b[15:0])) >> 16;
    if (force_en) return force_val;
    return (a[16] ^ b[16]) ? (32'h0 - m) : m;
  endfunction

  always @(posedge clk) begin
    ram_a_data <= ram_a_en ? mem_a[ram_a_addr] : DATA_W'($urandom);
    ram_b_data <= ram_b_en ? mem_b[ram_b_addr] : DATA_W'($urandom);
    if (!rst_n) begin
      for (int j = 0; j < LAT; j++) pipe[j] <= $urandom;
    end else if (mul_start) begin
      pipe[0] <= mul_model(mul_a, mul_b);
      for (int j = LAT - 1; j > 0; j--) pipe[j] <= pipe[j-1];
    end
  end
  assign mul_data = pipe[LAT-1];

  // ---------------- job-level reference model ----------------
  bit               job = 1'b0;
  int               t0, jn, jba, jbb, done_c;
  logic [ACC_W-1:0] exp_acc;
  bit               exp_ovf;

  function automatic void compute_job();
    longint maxv, minv, s, p;
    bit o;
    maxv = (longint'(1) <<< (ACC_W - 1)) - 1;
    minv = -(longint'(1) <<< (ACC_W - 1));
    s = 0;
    o = 1'b0;
    for (int k = 0; k < jn; k++) begin
      p = longint'($signed(mul_model(mem_a[(jba + k) % 256], mem_b[(jbb + k) % 256])));
      s = s + p;
      if (s > maxv) begin s = maxv; o = 1'b1; end
      if (s < minv) begin s = minv; o = 1'b1; end
    end
    exp_acc = s[ACC_W-1:0];
    exp_ovf = o;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      job = 1'b0;
    end else begin
      if (cmd_valid && (!job || cyc > done_c)) begin
        job = 1'b1;
        t0 = cyc;
        jn = int'(cmd_len);
        jba = int'(cmd_base_a);
        jbb = int'(cmd_base_b);
        done_c = t0 + ((jn == 0) ? 1 : jn + LAT + 2);
        compute_job();
      end
      cyc++;
    end
  end

  // ---------------- per-cycle compare and capture ----------------
  int          valid_cyc;
  logic [63:0] valid_acc;
  bit          valid_ovf;
  bit          ms_seen;
  logic [7:0]  addr_q [$];

  always @(negedge clk) begin
    int d;
    bit e_busy, e_iss, e_ms, e_done, e_res;
    if (rst_n) begin
      d = cyc - t0;
      e_busy = 1'b0; e_iss = 1'b0; e_ms = 1'b0; e_done = 1'b0; e_res = 1'b0;
      if (job) begin
        e_busy = (d >= 1) && (cyc <= done_c);
        e_iss  = (jn != 0) && (d >= 1) && (d <= jn);
        e_ms   = (jn != 0) && (d >= 1) && (d <= jn + LAT + 1);
        e_done = (cyc == done_c);
        e_res  = (cyc >= done_c);
      end
      chk("cmd_ready", cmd_ready, !e_busy);
      chk("busy", busy, e_busy);
      chk("ram_a_en", ram_a_en, e_iss);
      chk("ram_b_en", ram_b_en, e_iss);
      chk("mul_start", mul_start, e_ms);
      chk("acc_valid", acc_valid, e_done);
      if (e_iss) begin
        chk("ram_a_addr", ram_a_addr, (jba + d - 1) % 256);
        chk("ram_b_addr", ram_b_addr, (jbb + d - 1) % 256);
      end
      if (job && jn != 0 && d >= 2 && d <= jn + 1) begin
        chk("mul_a", mul_a, mem_a[(jba + d - 2) % 256]);
        chk("mul_b", mul_b, mem_b[(jbb + d - 2) % 256]);
      end
      if (e_res) begin
        chk("acc_out", acc_out, exp_acc);
        chk("acc_ovf", acc_ovf, exp_ovf);
      end else if (!job) begin
        chk("acc_out_idle", acc_out, 0);
        chk("acc_ovf_idle", acc_ovf, 0);
      end
      if (acc_valid) begin
        valid_cyc = cyc;
        valid_acc = 64'(acc_out);
        valid_ovf = acc_ovf;
      end
      if (ram_a_en) addr_q.push_back(ram_a_addr);
      if (mul_start) ms_seen = 1'b1;
    end
  end

  // ---------------- stimulus ----------------
  task automatic clear_capture();
    valid_cyc = -1;
    valid_acc = '1;
    valid_ovf = 1'b0;
    ms_seen = 1'b0;
    addr_q.delete();
  endtask

  task automatic start_cmd(input int n, input int ba, input int bb);
    @(negedge clk); #1;
    cmd_valid = 1'b1;
    cmd_len = LEN_W'(n);
    cmd_base_a = ADDR_W'(ba);
    cmd_base_b = ADDR_W'(bb);
    @(negedge clk); #1;
    // A second request while busy must be ignored.
    cmd_len = LEN_W'($urandom);
    cmd_base_a = ADDR_W'($urandom);
    cmd_base_b = ADDR_W'($urandom);
    @(negedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done();
    int i;
    for (i = 0; i < 400; i++) begin
      if (job && cyc > done_c) break;
      @(negedge clk);
    end
    if (i == 400) chk("job_timeout", 64'(i), 0);
  endtask

  task automatic run_cmd(input int n, input int ba, input int bb);
    clear_capture();
    start_cmd(n, ba, bb);
    wait_done();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cmd_ready"}, cmd_ready, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_ram_en"}, {ram_a_en, ram_b_en}, 0);
    chk({tag, "_addr"}, {ram_a_addr, ram_b_addr}, 0);
    chk({tag, "_mul_ab"}, {mul_a, mul_b}, 0);
    chk({tag, "_mul_start"}, mul_start, 0);
    chk({tag, "_acc_out"}, acc_out, 0);
    chk({tag, "_acc_valid"}, acc_valid, 0);
    chk({tag, "_acc_ovf"}, acc_ovf, 0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem_a[i] = DATA_W'($urandom);
      mem_b[i] = DATA_W'($urandom);
    end
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Positive sum: 0.75 * 0.25 four times.
    for (int k = 0; k < 4; k++) begin mem_a[10 + k] = 17'h0C000; mem_b[20 + k] = 17'h04000; end
    run_cmd(4, 10, 20);
    chk("pos_acc", valid_acc, 64'h0C000);
    chk("pos_latency", 64'(valid_cyc - t0), 16);
    chk("pos_ovf", valid_ovf, 0);

    // Negative operand: -0.5 * 0.5 twice.
    for (int k = 0; k < 2; k++) begin mem_a[30 + k] = 17'h18000; mem_b[40 + k] = 17'h08000; end
    run_cmd(2, 30, 40);
    chk("neg_acc", valid_acc, 64'h3_FFFF_8000);
    chk("neg_ovf", valid_ovf, 0);

    // Zero length.
    run_cmd(0, 5, 6);
    chk("zero_latency", 64'(valid_cyc - t0), 1);
    chk("zero_acc", valid_acc, 0);
    chk("zero_mul_start", ms_seen, 0);

    // Address wrap.
    run_cmd(4, 8'hFE, 8'h10);
    chk("wrap_count", 64'(addr_q.size()), 4);
    if (addr_q.size() == 4) begin
      chk("wrap_addr0", addr_q[0], 8'hFE);
      chk("wrap_addr1", addr_q[1], 8'hFF);
      chk("wrap_addr2", addr_q[2], 8'h00);
      chk("wrap_addr3", addr_q[3], 8'h01);
    end

    // Positive and negative saturation, then a clean command clears the flag.
    force_en = 1'b1;
    force_val = 32'h7FFF_FFFF;
    run_cmd(5, 50, 60);
    chk("satp_acc", valid_acc, 64'h1_FFFF_FFFF);
    chk("satp_ovf", valid_ovf, 1);
    force_val = 32'h8000_0000;
    run_cmd(5, 70, 80);
    chk("satn_acc", valid_acc, 64'h2_0000_0000);
    chk("satn_ovf", valid_ovf, 1);
    force_en = 1'b0;
    mem_a[90] = 17'h10000;
    mem_b[91] = 17'h10000;
    run_cmd(1, 90, 91);
    chk("clear_acc", valid_acc, 0);
    chk("clear_ovf", valid_ovf, 0);

    // Random jobs against the reference model.
    for (int r = 0; r < 24; r++) begin
      for (int i = 0; i < 256; i++) begin
        mem_a[i] = DATA_W'($urandom);
        mem_b[i] = DATA_W'($urandom);
      end
      force_en = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 2))
        0:       force_val = 32'h7FFF_FFFF;
        1:       force_val = 32'h8000_0000;
        default: force_val = $urandom;
      endcase
      run_cmd($urandom_range(0, 24), $urandom_range(0, 255), $urandom_range(0, 255));
    end
    force_en = 1'b0;

    // Reset while draining: immediate reset values and no result strobe.
    clear_capture();
    start_cmd(6, 100, 200);
    repeat (6) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("midrst");
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (30) @(negedge clk);
    chk("midrst_no_valid", 64'(valid_cyc), 64'(-1));

    run_cmd(3, 1, 2);
    chk("post_rst_latency", 64'(valid_cyc - t0), 15);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
